// File: rtl/bmf_partition_err_scanner.sv
// Self-test sweeper for a BMF-partitioned approximate sub-circuit: drives every input
// vector to approximate and exact partitions and accumulates error metrics in two stages.
module bmf_partition_err_scanner #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 4,
  parameter int HAM_W = 11,
  parameter int ERR_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  vec_out,
  output logic             vec_valid,
  input  logic [OUT_W-1:0] approx_in,
  input  logic [OUT_W-1:0] exact_in,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    mismatch_cnt,
  output logic [HAM_W-1:0] ham_sum,
  output logic [ERR_W-1:0] err_sum,
  output logic [OUT_W-1:0] max_abs_err,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam int PC_W = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [IN_W-1:0]     cnt;
  logic                accept;
  logic                stop;
  logic [OUT_W-1:0]    diff;
  logic [PC_W-1:0]     pc;
  logic signed [OUT_W:0] sdiff;
  logic [OUT_W-1:0]    absd;

  logic                s1_valid;
  logic                s1_flag;
  logic [PC_W-1:0]     s1_pc;
  logic [OUT_W-1:0]    s1_abs;
  logic [IN_W-1:0]     s1_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = DRIVE;
      DRIVE:   if (abort) state_nxt = IDLE;
               else if (&cnt) state_nxt = DRAIN;
      DRAIN:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vec_valid = (state == DRIVE);
    busy      = (state == DRIVE) || (state == DRAIN);
    done      = (state == DONE);
  end

  assign vec_out = cnt;
  assign accept  = (state == IDLE) && start && !abort;
  assign stop    = busy && abort;

  always_comb begin
    diff = approx_in ^ exact_in;
    pc   = '0;
    for (int unsigned i = 0; i < OUT_W; i++) pc = pc + PC_W'(diff[i]);
    sdiff = $signed({1'b0, approx_in}) - $signed({1'b0, exact_in});
    absd  = sdiff[OUT_W] ? OUT_W'(-sdiff) : sdiff[OUT_W-1:0];
  end

  // An abort drops both the sample being captured and the one waiting in stage 1.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cnt              <= '0;
      s1_valid         <= 1'b0;
      s1_flag          <= 1'b0;
      s1_pc            <= '0;
      s1_abs           <= '0;
      s1_idx           <= '0;
      mismatch_cnt     <= '0;
      ham_sum          <= '0;
      err_sum          <= '0;
      max_abs_err      <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      if (state == DRIVE && !abort && !(&cnt)) cnt <= cnt + 1'b1;
      s1_valid <= (state == DRIVE) && !abort;
      if (state == DRIVE) begin
        s1_flag <= |diff;
        s1_pc   <= pc;
        s1_abs  <= absd;
        s1_idx  <= cnt;
      end
      if (s1_valid && !stop) begin
        mismatch_cnt <= mismatch_cnt + (IN_W+1)'(s1_flag);
        ham_sum      <= ham_sum + HAM_W'(s1_pc);
        err_sum      <= err_sum + ERR_W'(s1_abs);
        if (s1_abs > max_abs_err) max_abs_err <= s1_abs;
        if (s1_flag && !first_fail_valid) begin
          first_fail_vec   <= s1_idx;
          first_fail_valid <= 1'b1;
        end
      end
    end
  end

endmodule
